// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS execute stage: ALU/muldiv op codes and muldiv FSM state.
`timescale 1ns/1ps
package pipe_pkg;
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MFHI  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;

    typedef enum logic {IDLE, BUSY} md_state_t;

    function automatic logic md_is_start(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction
endpackage

// File: rtl/pipe_exe_stage_if.sv
// ID/EXE inputs and EXE/MEM outputs of the execute stage; master is the pipeline side, slave the stage.
`timescale 1ns/1ps
interface pipe_exe_stage_if;
    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern;
    logic [3:0]  ealuc;
    logic        ealuimm, eshift, ejal;
    logic        ewreg, em2reg, ewmem;
    logic [2:0]  emd;
    logic [31:0] ealu;
    logic [4:0]  ern0;
    logic [31:0] eb_o;
    logic        ewreg_o, em2reg_o, ewmem_o;
    logic        estall;
    logic [31:0] hi, lo;

    modport master (
        output ea, eb, eimm, epc4, ern, ealuc, ealuimm, eshift, ejal,
               ewreg, em2reg, ewmem, emd,
        input  ealu, ern0, eb_o, ewreg_o, em2reg_o, ewmem_o, estall, hi, lo
    );
    modport slave (
        input  ea, eb, eimm, epc4, ern, ealuc, ealuimm, eshift, ejal,
               ewreg, em2reg, ewmem, emd,
        output ealu, ern0, eb_o, ewreg_o, em2reg_o, ewmem_o, estall, hi, lo
    );
endinterface

// File: rtl/pipe_muldiv.sv
// Iterative multiply (shift-add) / divide (restoring) unit on operand magnitudes, with HI/LO registers.
`timescale 1ns/1ps
module pipe_muldiv
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        last,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(MD_CYCLES);

    md_state_t   state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]  op_reg;
    logic        sa_reg, sb_reg;
    logic [31:0] mb_reg;   // multiplicand / divisor magnitude
    logic [31:0] acc_reg;  // product high half / partial remainder
    logic [31:0] q_reg;    // multiplier shifting out / quotient shifting in
    logic [31:0] hi_reg, lo_reg;

    logic        is_signed, is_div, op_signed;
    logic [32:0] sum, shifted;
    logic        ge;
    logic [31:0] acc_next, q_next, hi_next, lo_next;
    logic [63:0] prod;

    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign is_signed = (op_reg == MD_MULT) || (op_reg == MD_DIV);
    assign is_div    = (op_reg == MD_DIV) || (op_reg == MD_DIVU);

    always_comb begin
        sum      = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, mb_reg} : 33'd0);
        shifted  = {acc_reg, q_reg[31]};
        ge       = shifted >= {1'b0, mb_reg};
        acc_next = '0;
        q_next   = '0;
        if (is_div) begin
            acc_next = ge ? (shifted[31:0] - mb_reg) : shifted[31:0];
            q_next   = {q_reg[30:0], ge};
        end else begin
            acc_next = sum[32:1];
            q_next   = {sum[0], q_reg[31:1]};
        end
    end

    // A zero divisor lets every subtract succeed, so the remainder ends as |a|; the sign fix-up restores a.
    always_comb begin
        prod    = {acc_next, q_next};
        hi_next = '0;
        lo_next = '0;
        if (is_div) begin
            lo_next = (is_signed && (sa_reg ^ sb_reg)) ? -q_next : q_next;
            hi_next = (is_signed && sa_reg) ? -acc_next : acc_next;
            if (mb_reg == '0)
                lo_next = '1;
        end else begin
            if (is_signed && (sa_reg ^ sb_reg))
                prod = -prod;
            {hi_next, lo_next} = prod;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= MD_NONE;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            mb_reg    <= '0;
            acc_reg   <= '0;
            q_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    state_reg <= BUSY;
                    cnt_reg   <= '0;
                    op_reg    <= op;
                    sa_reg    <= op_signed & a[31];
                    sb_reg    <= op_signed & b[31];
                    q_reg     <= (op_signed && a[31]) ? -a : a;
                    mb_reg    <= (op_signed && b[31]) ? -b : b;
                    acc_reg   <= '0;
                end
                BUSY: begin
                    acc_reg <= acc_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(MD_CYCLES - 1)) begin
                        state_reg <= IDLE;
                        hi_reg    <= hi_next;
                        lo_reg    <= lo_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg == BUSY);
    assign last = busy && (cnt_reg == CW'(MD_CYCLES - 1));
    assign hi   = hi_reg;
    assign lo   = lo_reg;
endmodule

// File: rtl/pipe_exe_stage.sv
// MIPS execute stage: operand muxing, single-cycle ALU, result select and stall/bubble control.
`timescale 1ns/1ps
module pipe_exe_stage
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            clrn,
    pipe_exe_stage_if.slave bus
);
    logic [31:0] opa, opb, alu_res;
    logic        md_start, md_busy, md_last;
    logic [31:0] md_hi, md_lo;
    logic        stall;

    assign opa      = bus.eshift  ? {27'b0, bus.eimm[10:6]} : bus.ea;
    assign opb      = bus.ealuimm ? bus.eimm : bus.eb;
    assign md_start = md_is_start(bus.emd);

    always_comb begin
        alu_res = '0;
        casez (bus.ealuc)
            4'b?000: alu_res = opa + opb;
            4'b?100: alu_res = opa - opb;
            4'b?001: alu_res = opa & opb;
            4'b?101: alu_res = opa | opb;
            4'b?010: alu_res = opa ^ opb;
            4'b?110: alu_res = {opb[15:0], 16'b0};
            ALUC_SLL: alu_res = opb << opa[4:0];
            ALUC_SRL: alu_res = opb >> opa[4:0];
            ALUC_SRA: alu_res = $signed(opb) >>> opa[4:0];
            default:  alu_res = '0;
        endcase
    end

    pipe_muldiv #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
        .clk   (clk),
        .clrn  (clrn),
        .start (md_start),
        .op    (bus.emd),
        .a     (bus.ea),
        .b     (bus.eb),
        .busy  (md_busy),
        .last  (md_last),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // Stall covers the issue cycle plus every busy cycle except the final one; held low during reset.
    assign stall = clrn && ((!md_busy && md_start) || (md_busy && !md_last));

    assign bus.ealu = bus.ejal              ? bus.epc4 + 32'd4 :
                      (bus.emd == MD_MFHI)  ? md_hi :
                      (bus.emd == MD_MFLO)  ? md_lo : alu_res;
    assign bus.ern0     = bus.ejal ? 5'd31 : bus.ern;
    assign bus.eb_o     = bus.eb;
    assign bus.ewreg_o  = bus.ewreg  & ~stall;
    assign bus.em2reg_o = bus.em2reg & ~stall;
    assign bus.ewmem_o  = bus.ewmem  & ~stall;
    assign bus.estall   = stall;
    assign bus.hi       = md_hi;
    assign bus.lo       = md_lo;
endmodule
